// File: rtl/jtdsp16_prom.sv
// jtdsp16_prom: DSP16 program memory with byte-wide loader, checksum and configurable read latency
module jtdsp16_prom #(
    parameter int AW      = 12,
    parameter int DW      = 16,
    parameter int LATENCY = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] addr_i,
    output logic [DW-1:0] dout_o,
    output logic          rd_ok_o,
    input  logic          prog_start_i,
    input  logic [7:0]    prog_byte_i,
    input  logic          prog_strobe_i,
    output logic          prog_busy_o,
    output logic          prog_done_o,
    output logic [15:0]   prog_sum_o
);
    if (DW != 16) begin : g_bad_dw
        $error("jtdsp16_prom: DW must be 16");
    end
    if (LATENCY != 1 && LATENCY != 2) begin : g_bad_lat
        $error("jtdsp16_prom: LATENCY must be 1 or 2");
    end

    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   ptr_q, ptr_d;
    logic [7:0]      latch_q, latch_d;
    logic [15:0]     sum_q, sum_d;
    logic [DW-1:0]   rd_q;
    logic [DW-1:0]   mem_q [0:2**AW-1];
    logic [DW-1:0]   wr_word;
    logic            lo_en, wr_en;

    assign lo_en   = !prog_start_i && prog_strobe_i && state_q == LO;
    assign wr_en   = !prog_start_i && prog_strobe_i && state_q == HI;
    assign wr_word = {prog_byte_i, latch_q};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            latch_q <= '0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            latch_q <= latch_d;
            sum_q   <= sum_d;
        end
    end

    always_comb begin
        state_d = prog_start_i ? LO :
                  lo_en        ? HI :
                  wr_en        ? (ptr_q == '1 ? DONE : LO) : state_q;
        // pointer wraps to 0 naturally after the last address
        ptr_d   = prog_start_i ? '0 : wr_en ? ptr_q + 1'b1 : ptr_q;
        latch_d = lo_en ? prog_byte_i : latch_q;
        sum_d   = prog_start_i ? '0 : wr_en ? sum_q + wr_word : sum_q;
    end

    always_comb begin
        prog_busy_o = state_q == LO || state_q == HI;
        prog_done_o = state_q == DONE;
        rd_ok_o     = !prog_busy_o;
        prog_sum_o  = sum_q;
    end

    // memory is never cleared; the read register sees the pre-write word (read-first)
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[ptr_q] <= wr_word;
    end

    always_ff @(posedge clk) begin
        rd_q <= rst ? '0 : mem_q[addr_i];
    end

    if (LATENCY == 2) begin : g_lat2
        logic [DW-1:0] pipe_q;
        always_ff @(posedge clk) begin
            pipe_q <= rst ? '0 : rd_q;
        end
        assign dout_o = pipe_q;
    end else begin : g_lat1
        assign dout_o = rd_q;
    end
endmodule

// File: doc/jtdsp16_prom.md
# jtdsp16_prom

Parametrised program memory for the DSP16 core with a built-in byte-wide loader. The host streams bytes that are assembled little-endian into DW-bit words and written at auto-incrementing addresses, while the sequencer reads through a synchronous port of configurable latency. A running checksum and busy/done flags let the host confirm a complete download before releasing the core.

## Interface
- AW, 12: address width; depth is 2^AW words.
- DW, 16: word width; fixed at 16 for this block, checked at elaboration.
- LATENCY, 1: read latency in cycles; legal values 1 or 2, anything else is an elaboration error.

- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- addr  in  AW  read address from sequencer.
- dout  out  DW  read data.
- rd_ok  out  1  high when no download is in progress, so dout reflects a stable image.
- prog_start  in  1  one-cycle pulse: begin a download at address 0.
- prog_byte  in  8  download byte.
- prog_strobe  in  1  one-cycle qualifier for prog_byte.
- prog_busy  out  1  download in progress.
- prog_done  out  1  last address written; held until next prog_start or rst.
- prog_sum  out  16  modulo-2^16 sum of all words written since prog_start.

## Operation
- States: IDLE, LO (expect low byte), HI (expect high byte), DONE.
- Reset: state IDLE; write pointer 0; byte latch 0; prog_sum 0; prog_busy 0; prog_done 0; dout 0 (both pipeline stages when LATENCY=2); rd_ok 1. Memory contents are not cleared.
- prog_start in any state -> LO, pointer 0, prog_sum 0, prog_done 0. A prog_strobe in the same cycle is discarded.
- LO + prog_strobe: latch prog_byte as bits [7:0] -> HI.
- HI + prog_strobe: write {prog_byte, latch} at pointer; prog_sum += word (carry dropped). If pointer == 2^AW-1, go to DONE and leave pointer at 0 (wraps). Otherwise increment pointer and go to LO.
- prog_strobe in IDLE or DONE is ignored; there is no write and no state change.
- prog_busy = state is LO or HI. rd_ok = !prog_busy. prog_done = state is DONE.
- Read port runs in every state; during download dout may show partially loaded data, which rd_ok flags.
- Read-during-write to the same address returns the old word (read-first).
- Aborting a download via prog_start keeps already written words; only the pointer and sum restart.
- rst mid-download returns to IDLE. Words already written persist; the half-assembled word is lost.

## Timing
- Write takes effect at the clock edge that samples the HI strobe. A read of that address issued on the following cycle returns the new word.
- LATENCY=1: addr sampled at edge N, dout valid after edge N. LATENCY=2: one extra output register, dout valid after edge N+1. Throughput is one read per cycle in both cases.
- prog_busy rises the cycle after prog_start.
- prog_done and prog_sum final value appear the cycle after the last HI strobe. prog_busy falls in the same cycle.
- Strobes may arrive back-to-back every cycle. Minimum full load is 2·2^AW strobe cycles.

## Test plan
- Reset: assert rst 2 cycles -> dout=0, prog_busy=0, prog_done=0, prog_sum=0, rd_ok=1.
- Full load, AW=4: prog_start, then 32 back-to-back bytes giving words 0x1000+i for i=0..15 -> prog_done=1, prog_sum=0x0078. Reads of addresses 0..15 return 0x1000..0x100F at LATENCY cycles each, for LATENCY=1 and LATENCY=2.
- Gapped strobes: bytes 0x34 then 0x12 with 5 idle cycles between -> address 0 holds 0x1234, prog_busy stays 1 throughout.
- Abort: load 3 words (0xAAAA, 0xBBBB, 0xCCCC), prog_start, load 0x1111 -> address 0 = 0x1111, address 1 = 0xBBBB, prog_sum = 0x1111.
- Collisions: prog_start with prog_strobe (byte 0xFF) in the same cycle -> byte dropped, first word taken from the next two bytes. A strobe after DONE -> no write, prog_sum unchanged. Same-cycle read/write at address 5 -> old value, then new value the next cycle.
- Reset mid-load after a low byte only -> IDLE, target word unchanged, later strobes ignored until prog_start.
